fixed_to_float_seq: RTL

Sequential converter that takes the registered two's-complement fixed-point result of the float-to-fixed stage and packs it back into IEEE-754 single precision. It finds the leading one with a one-bit-per-cycle normalisation loop. It sits directly downstream of the float-to-fixed converter in the natural-logarithm datapath and feeds the float result bus. A START/READY handshake is controlled by the datapath sequencer.

---
 rtl/fixed_to_float_pkg.sv | 20 ++
 rtl/fixed_to_float_ctrl.sv | 71 +++++++
 rtl/fixed_to_float_seq.sv | 86 ++++++++
 3 files changed

// File: rtl/fixed_to_float_pkg.sv
// Shared types and constants for the fixed/float conversion stages.
// Combinational definitions only; no latency.
// No flow control of its own.
package fixed_to_float_pkg;

   // Conversion FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_NORM,
      ST_PACK,
      ST_DONE
   } state_t;

   localparam int BIAS     = 127;
   localparam int EXP_BASE = 128;
   localparam int MANT_W   = 23;
   localparam int EXP_W    = 8;

endpackage

// File: rtl/fixed_to_float_ctrl.sv
// Conversion sequencer: issues load/magnitude/shift/pack enables, drives BUSY/READY.
// Latency: s+3 edges from accepted START to READY (2 edges for a zero operand).
// START is honoured only in IDLE; it is ignored while BUSY.
module fixed_to_float_ctrl
   import fixed_to_float_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_zero,
   input  logic i_msb,
   output logic o_load,
   output logic o_mag,
   output logic o_shift,
   output logic o_pack,
   output logic o_busy,
   output logic o_ready
);

   state_t r_state;
   state_t w_next;

   // State register plus registered BUSY/READY, decoded from the next state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         o_busy  <= 1'b0;
         o_ready <= 1'b0;
      end else begin
         r_state <= w_next;
         o_busy  <= (w_next != ST_IDLE);
         o_ready <= (w_next == ST_DONE);
      end
   end

   // Next-state and datapath enables
   always_comb begin
      w_next  = r_state;
      o_load  = 1'b0;
      o_mag   = 1'b0;
      o_shift = 1'b0;
      o_pack  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               o_load = 1'b1;
               w_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_mag  = 1'b1;
            // Negation preserves zero-ness, so W==0 here means a zero magnitude.
            w_next = i_zero ? ST_PACK : ST_NORM;
         end
         ST_NORM: begin
            if (i_msb) begin
               w_next = ST_PACK;
            end else begin
               o_shift = 1'b1;
            end
         end
         ST_PACK: begin
            o_pack = 1'b1;
            w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/fixed_to_float_seq.sv
// Q2.30 two's-complement to IEEE-754 single, leading-one search one bit per cycle.
// Latency: READY the cycle after edge s+3 (edge 2 for zero); mantissa truncated.
// START accepted only when not BUSY; result held until the next conversion packs.
module fixed_to_float_seq
   import fixed_to_float_pkg::*;
#(
   parameter int P    = 32,
   parameter int FRAC = 30
)(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [P-1:0] i_fixed_in,
   output logic         o_busy,
   output logic         o_ready,
   output logic [P-1:0] o_float_out,
   output logic [4:0]   o_shift_cnt
);

   // Exponent of a value whose leading one sits in bit P-1 of the working word
   localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + (P - 1 - FRAC));

   logic [P-1:0]     r_w;
   logic [4:0]       r_s;
   logic             r_sign;
   logic             r_zero;

   logic             w_load;
   logic             w_mag_en;
   logic             w_shift;
   logic             w_pack;
   logic [P-1:0]     w_mag;
   logic [EXP_W-1:0] w_exp;

   assign w_mag = r_w[P-1] ? ({P{1'b0}} - r_w) : r_w;
   assign w_exp = EXP_TOP - {{(EXP_W-5){1'b0}}, r_s};

   fixed_to_float_ctrl u_ctrl (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_zero  (r_w == {P{1'b0}}),
      .i_msb   (r_w[P-1]),
      .o_load  (w_load),
      .o_mag   (w_mag_en),
      .o_shift (w_shift),
      .o_pack  (w_pack),
      .o_busy  (o_busy),
      .o_ready (o_ready)
   );

   // Working register, shift count, sign/zero flags and result register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_w         <= '0;
         r_s         <= '0;
         r_sign      <= 1'b0;
         r_zero      <= 1'b0;
         o_float_out <= '0;
         o_shift_cnt <= '0;
      end else begin
         if (w_load) begin
            r_w <= i_fixed_in;
         end
         if (w_mag_en) begin
            r_sign <= r_w[P-1];
            r_zero <= (r_w == {P{1'b0}});
            r_w    <= w_mag;
            r_s    <= '0;
         end
         if (w_shift) begin
            r_w <= r_w << 1;
            r_s <= r_s + 5'd1;
         end
         if (w_pack) begin
            o_shift_cnt <= r_s;
            if (r_zero) begin
               o_float_out <= '0;
            end else begin
               o_float_out <= {r_sign, w_exp, r_w[P-2 -: MANT_W]};
            end
         end
      end
   end

endmodule
